data_mem_port: RTL and testbench
================================

# data_mem_port

Parametrised, byte-addressable data memory for the CPU's load/store path. It is the successor to the fixed single-byte data memory. It adds byte, halfword and word accesses in big-endian order, matching instruction byte order in the program cache. It also adds a request/ack handshake with configurable wait states, alignment and range checking, and sign- or zero-extension on loads. It sits between the execute stage's load/store unit and the backing byte array.

## Interface
Parameters:
- `DEPTH`, 1024: memory size in bytes; must be a power of two and ≥ 4.
- `ADDR_W`, 32: width of `mem_addr`; addresses ≥ `DEPTH` are out of range.
- `WAIT_CYCLES`, 2: wait states inserted between request acceptance and completion; 0 is legal.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 1: request strobe; sampled only when `busy`=0.
- `rw_mem` input 1: 1 = read, 0 = write (same encoding as `READ_VALID`/`WRITE_VALID`).
- `size` input 2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- `sign_ext` input 1: for reads, 1 = sign-extend, 0 = zero-extend; ignored on writes.
- `mem_addr` input ADDR_W: byte address of the most significant byte.
- `din` input 32: write data, right-justified (byte uses [7:0], half uses [15:0]).
- `busy` output 1: high from the cycle after acceptance until completion.
- `mem_ref` output 1: one-cycle completion pulse (`FULL` = 1).
- `err` output 1: valid while `mem_ref`=1; flags a rejected access.
- `dout` output 32: read data, right-justified and extended; holds until the next completion.

## Operation
- Storage is `DEPTH` × 8-bit, zero-initialised at time 0. Reset does not clear it.
- FSM states:
  - IDLE: if `req`=1, latch `rw_mem`, `size`, `sign_ext`, `mem_addr` and `din`. Load the wait counter with `WAIT_CYCLES`. Go to WAIT, or straight to DONE when `WAIT_CYCLES`=0.
  - WAIT: decrement the counter each cycle. Go to DONE when it reaches 1.
  - DONE: perform the access, pulse `mem_ref`, then go to IDLE.
- Error conditions, all checked on the latched request:
  - `size`=11.
  - Halfword with addr[0]≠0.
  - Word with addr[1:0]≠0.
  - addr + bytes − 1 ≥ `DEPTH`.
- On error: no memory change, `err`=1, `dout`=0.
- Byte order is big-endian:
  - Word read = {m[a], m[a+1], m[a+2], m[a+3]}.
  - Halfword write puts din[15:8] at m[a] and din[7:0] at m[a+1].
- Extension: byte reads extend from bit 7, halfword reads from bit 15; word reads are unaffected.
- Writes commit only in DONE. `dout` is unchanged by a successful write and is set to 0 on an errored access.
- `req` while `busy`=1 is ignored, not queued. The requester must hold its fields only for the accepting cycle.

## Timing
- Reset values: state IDLE, `busy`=0, `mem_ref`=0, `err`=0, `dout`=0.
- Latency: `req` accepted at edge N gives `mem_ref`=1 in cycle N+WAIT_CYCLES+1. Memory write and `dout` update take effect at the same edge.
- `busy`=1 from cycle N+1 through the `mem_ref` cycle inclusive; `busy`=0 in the cycle after.
- Back-to-back operation: a new `req` is accepted in the first cycle with `busy`=0. Throughput is one access per WAIT_CYCLES+2 cycles.
- Reset mid-operation (WAIT or DONE not yet reached):
  - The access is aborted and a pending write is not committed.
  - No `mem_ref` pulse is produced.
  - Outputs return to reset values on the next cycle.
- `rst` and `req` in the same cycle: reset wins and the request is dropped.

## Test plan
- Reset, then with `WAIT_CYCLES`=2: write word 0x97105EE4 to addr 0x10, then read word 0x10 → `mem_ref` exactly 3 cycles after each accept, `dout`=0x97105EE4, `err`=0.
- Read bytes 0x10..0x13 with `sign_ext`=1 → 0xFFFFFF97, 0x00000010, 0x0000005E, 0xFFFFFFE4. Read halfword 0x12 with `sign_ext`=0 → 0x00005EE4.
- Halfword write 0xC164 to 0x20, then byte write 0xAB to 0x22, then word read 0x20 → 0xC164AB00. Repeat with `WAIT_CYCLES`=0 and check `mem_ref` one cycle after each accept.
- Errors:
  - Word read at 0x11 → `err`=1, `dout`=0, memory unchanged.
  - Halfword write at 0x3FF (`DEPTH`=1024) → `err`=1, m[0x3FF] unchanged.
  - `size`=11 → `err`=1.
- Issue `req` while `busy` with write 0xFF to 0x30 → ignored, and m[0x30] reads back 0x00. Assert `rst` during WAIT of a word write 0x12345678 to 0x40 → no `mem_ref`, and a later read returns 0x00000000.
- Assert `rst` and `req` in the same cycle → request dropped: no `busy`, no `mem_ref`.

Source files
------------

// File: rtl/data_mem_port.sv
// Byte-addressable big-endian data memory for the load/store path, with a req/ack
// handshake, configurable wait states, alignment/range checking and load extension.
module data_mem_port #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw_mem,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       din,
  output logic              busy,
  output logic              mem_ref,
  output logic              err,
  output logic [31:0]       dout
);

  localparam int unsigned Words  = DEPTH / 4;
  localparam int unsigned WordAw = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned CntW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_W:0] DepthA = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fire;

  logic              rw_q, sext_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic              err_q;
  logic [31:0]       dout_q;

  // Aligned accesses never straddle a word, so storage is kept as big-endian words.
  logic [31:0]       mem_q [Words];

  logic              s_rw, s_sext;
  logic [1:0]        s_size;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_din;
  logic [1:0]        nbytes_m1;
  logic              misalign, bad_size, acc_err;
  logic [ADDR_W:0]   last_addr;
  logic [WordAw-1:0] widx;
  logic [1:0]        lane;
  logic [31:0]       rword, rdata, wdata, wmask;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;

  // With zero wait states the access completes off the accepting edge, so it
  // must see the live request rather than the latched copy.
  always_comb begin
    s_rw   = rw_q;
    s_sext = sext_q;
    s_size = size_q;
    s_addr = addr_q;
    s_din  = din_q;
    if (state_q == StIdle) begin
      s_rw   = rw_mem;
      s_sext = sign_ext;
      s_size = size;
      s_addr = mem_addr;
      s_din  = din;
    end
  end

  always_comb begin
    nbytes_m1 = 2'd3;
    misalign  = 1'b0;
    bad_size  = 1'b0;
    case (s_size)
      2'b00:   nbytes_m1 = 2'd0;
      2'b01: begin
        nbytes_m1 = 2'd1;
        misalign  = s_addr[0];
      end
      2'b10: begin
        nbytes_m1 = 2'd3;
        misalign  = |s_addr[1:0];
      end
      default: bad_size = 1'b1;
    endcase
    last_addr = {1'b0, s_addr} + {{(ADDR_W - 1){1'b0}}, nbytes_m1};
    acc_err   = bad_size | misalign | (last_addr >= DepthA);

    widx  = s_addr[WordAw+1:2];
    lane  = s_addr[1:0];
    rword = mem_q[widx];
    case (lane)
      2'd0:    rbyte = rword[31:24];
      2'd1:    rbyte = rword[23:16];
      2'd2:    rbyte = rword[15:8];
      default: rbyte = rword[7:0];
    endcase
    rhalf = s_addr[1] ? rword[15:0] : rword[31:16];

    rdata = '0;
    wdata = '0;
    wmask = '0;
    case (s_size)
      2'b00: begin
        rdata = {{24{s_sext & rbyte[7]}}, rbyte};
        wdata = {4{s_din[7:0]}};
        wmask = 32'hFF00_0000 >> {lane, 3'b000};
      end
      2'b01: begin
        rdata = {{16{s_sext & rhalf[15]}}, rhalf};
        wdata = {2{s_din[15:0]}};
        wmask = s_addr[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      end
      2'b10: begin
        rdata = rword;
        wdata = s_din;
        wmask = '1;
      end
      default: ;
    endcase
  end

  // fire marks the edge that enters StDone: the access commits there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StDone;
            fire    = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(WAIT_CYCLES);
          end
        end
      end
      StWait: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fire) begin
        err_q <= acc_err;
        if (acc_err) begin
          dout_q <= '0;
        end else if (s_rw) begin
          dout_q <= rdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StIdle && req) begin
      rw_q   <= rw_mem;
      sext_q <= sign_ext;
      size_q <= size;
      addr_q <= mem_addr;
      din_q  <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fire && !s_rw && !acc_err) begin
      mem_q[widx] <= (rword & ~wmask) | (wdata & wmask);
    end
  end

  assign busy    = (state_q != StIdle);
  assign mem_ref = (state_q == StDone);
  assign err     = mem_ref & err_q;
  assign dout    = dout_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: two instances (2 and 0 wait states) checked every
// cycle against a byte-array transaction model, plus literal per-access expectations.
module tb_data_mem_port;

  localparam int unsigned W0 = 2;
  localparam int unsigned W1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst    = 1'b1;
  logic [1:0]       req_s  = '0;
  logic [1:0]       rw_s   = '0;
  logic [1:0]       sx_s   = '0;
  logic [1:0][1:0]  size_s = '0;
  logic [1:0][31:0] addr_s = '0;
  logic [1:0][31:0] din_s  = '0;
  logic [1:0]       busy_o, ref_o, err_o;
  logic [1:0][31:0] dout_o;

  data_mem_port #(.DEPTH(1024), .ADDR_W(32), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req_s[0]), .rw_mem(rw_s[0]), .size(size_s[0]),
    .sign_ext(sx_s[0]), .mem_addr(addr_s[0]), .din(din_s[0]), .busy(busy_o[0]),
    .mem_ref(ref_o[0]), .err(err_o[0]), .dout(dout_o[0])
  );

  data_mem_port #(.DEPTH(1024), .ADDR_W(32), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req_s[1]), .rw_mem(rw_s[1]), .size(size_s[1]),
    .sign_ext(sx_s[1]), .mem_addr(addr_s[1]), .din(din_s[1]), .busy(busy_o[1]),
    .mem_ref(ref_o[1]), .err(err_o[1]), .dout(dout_o[1])
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  mmem [2][1024];
  logic        m_busy [2];
  logic        m_ref  [2];
  logic        m_err  [2];
  logic [31:0] m_dout [2];
  int          m_left [2];
  logic        l_rw   [2];
  logic        l_sx   [2];
  logic [1:0]  l_size [2];
  logic [31:0] l_addr [2];
  logic [31:0] l_din  [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_access(input int d);
    int n;
    longint a;
    int ai;
    logic bad;
    logic [31:0] v;
    a = longint'(l_addr[d]);
    case (l_size[d])
      2'd0:    n = 1;
      2'd1:    n = 2;
      2'd2:    n = 4;
      default: n = 0;
    endcase
    bad = 1'b0;
    if (n == 0) bad = 1'b1;
    else if (a % n != 0) bad = 1'b1;
    else if (a + n - 1 >= 1024) bad = 1'b1;
    m_ref[d] = 1'b1;
    m_err[d] = bad;
    if (bad) begin
      m_dout[d] = '0;
    end else begin
      ai = int'(a);
      if (l_rw[d]) begin
        v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mmem[d][ai + i]};
        if (l_sx[d] && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        m_dout[d] = v;
      end else begin
        for (int i = 0; i < n; i++) mmem[d][ai + i] = 8'(l_din[d] >> (8 * (n - 1 - i)));
      end
    end
  endtask

  // Advances one DUT's expected outputs by one clock, given the inputs it will sample.
  task automatic model_step(input int d, input int w);
    if (rst) begin
      m_busy[d] = 1'b0;
      m_ref[d]  = 1'b0;
      m_err[d]  = 1'b0;
      m_dout[d] = '0;
      m_left[d] = 0;
    end else if (!m_busy[d]) begin
      if (req_s[d]) begin
        l_rw[d]   = rw_s[d];
        l_sx[d]   = sx_s[d];
        l_size[d] = size_s[d];
        l_addr[d] = addr_s[d];
        l_din[d]  = din_s[d];
        m_busy[d] = 1'b1;
        m_left[d] = w;
        if (w == 0) model_access(d);
      end
    end else if (m_ref[d]) begin
      m_busy[d] = 1'b0;
      m_ref[d]  = 1'b0;
    end else begin
      m_left[d]--;
      if (m_left[d] == 0) model_access(d);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 1024; i++) mmem[d][i] = 8'h00;
      m_busy[d] = 1'b0;
      m_ref[d]  = 1'b0;
      m_err[d]  = 1'b0;
      m_dout[d] = '0;
      m_left[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("cyc busy%0d", d), 32'(busy_o[d]), 32'(m_busy[d]));
        chk($sformatf("cyc mem_ref%0d", d), 32'(ref_o[d]), 32'(m_ref[d]));
        chk($sformatf("cyc dout%0d", d), dout_o[d], m_dout[d]);
        if (m_ref[d]) chk($sformatf("cyc err%0d", d), 32'(err_o[d]), 32'(m_err[d]));
      end
      model_step(0, W0);
      model_step(1, W1);
    end
  end

  task automatic drive(input int d, input logic rw, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    req_s[d]  = 1'b1;
    rw_s[d]   = rw;
    size_s[d] = sz;
    sx_s[d]   = sx;
    addr_s[d] = a;
    din_s[d]  = wd;
  endtask

  // One access; fields are scrambled after acceptance to prove they were latched.
  task automatic acc(input int d, input logic rw, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd, input logic exp_e,
                     input logic chk_d, input logic [31:0] exp_d, input string nm);
    int lat;
    @(posedge clk);
    #1 drive(d, rw, sz, sx, a, wd);
    @(posedge clk);
    #1;
    req_s[d]  = 1'b0;
    rw_s[d]   = ~rw;
    addr_s[d] = ~a;
    din_s[d]  = ~wd;
    sx_s[d]   = ~sx;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ref_o[d] && lat < 20);
    chk({nm, " latency"}, lat, (d == 0) ? 32'd3 : 32'd1);
    chk({nm, " err"}, 32'(err_o[d]), 32'(exp_e));
    if (chk_d) chk({nm, " dout"}, dout_o[d], exp_d);
  endtask

  initial begin
    int lat;
    int cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset busy", 32'(busy_o[d]), 32'd0);
      chk("reset mem_ref", 32'(ref_o[d]), 32'd0);
      chk("reset err", 32'(err_o[d]), 32'd0);
      chk("reset dout", dout_o[d], 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    acc(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h9710_5EE4, 1'b0, 1'b0, 32'h0, "wr word 0x10");
    acc(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h9710_5EE4, "rd word 0x10");
    acc(0, 1'b1, 2'd0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF97, "rd sbyte 0x10");
    acc(0, 1'b1, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0, 1'b1, 32'h0000_0010, "rd sbyte 0x11");
    acc(0, 1'b1, 2'd0, 1'b1, 32'h12, 32'h0, 1'b0, 1'b1, 32'h0000_005E, "rd sbyte 0x12");
    acc(0, 1'b1, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFE4, "rd sbyte 0x13");
    acc(0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0, 1'b1, 32'h0000_5EE4, "rd uhalf 0x12");

    for (int d = 0; d < 2; d++) begin
      acc(d, 1'b0, 2'd1, 1'b0, 32'h20, 32'h0000_C164, 1'b0, 1'b0, 32'h0, "wr half 0x20");
      acc(d, 1'b0, 2'd0, 1'b0, 32'h22, 32'h0000_00AB, 1'b0, 1'b0, 32'h0, "wr byte 0x22");
      acc(d, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'hC164_AB00, "rd word 0x20");
    end
    acc(1, 1'b1, 2'd2, 1'b0, 32'h11, 32'h0, 1'b1, 1'b1, 32'h0, "w0 misaligned word");

    acc(0, 1'b1, 2'd2, 1'b0, 32'h11, 32'h0, 1'b1, 1'b1, 32'h0, "misaligned word");
    acc(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h9710_5EE4, "word after err");
    acc(0, 1'b0, 2'd1, 1'b0, 32'h3FF, 32'h0000_BEEF, 1'b1, 1'b1, 32'h0, "half wr 0x3FF");
    acc(0, 1'b1, 2'd0, 1'b0, 32'h3FF, 32'h0, 1'b0, 1'b1, 32'h0, "byte 0x3FF kept");
    acc(0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0, "reserved size");
    acc(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'h0, 1'b1, 1'b1, 32'h0, "word out of range");
    acc(0, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'hA1B2_C3D4, 1'b0, 1'b0, 32'h0, "wr last word");
    acc(0, 1'b1, 2'd2, 1'b0, 32'h3FC, 32'h0, 1'b0, 1'b1, 32'hA1B2_C3D4, "rd last word");

    // A request presented while busy must be dropped.
    @(posedge clk);
    #1 drive(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1 drive(0, 1'b0, 2'd0, 1'b0, 32'h30, 32'h0000_00FF);
    @(posedge clk);
    #1 req_s[0] = 1'b0;
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
    end while (!ref_o[0] && lat < 20);
    chk("busy-ignore latency", lat, 32'd3);
    chk("busy-ignore dout", dout_o[0], 32'h9710_5EE4);
    acc(0, 1'b1, 2'd0, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 32'h0, "rd byte 0x30");

    // Reset while the write is still waiting.
    @(posedge clk);
    #1 drive(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h1234_5678);
    @(posedge clk);
    #1;
    req_s[0] = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (ref_o[0]) cnt++;
    end
    chk("abort mem_ref count", cnt, 32'd0);
    chk("abort busy", 32'(busy_o[0]), 32'd0);
    acc(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h0, "rd word 0x40");

    // Reset and request together: reset wins.
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1'b0, 2'd2, 1'b0, 32'h50, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    req_s[0] = 1'b0;
    @(negedge clk);
    chk("rst+req busy", 32'(busy_o[0]), 32'd0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ref_o[0] || busy_o[0]) cnt++;
    end
    chk("rst+req activity", cnt, 32'd0);
    acc(0, 1'b1, 2'd2, 1'b0, 32'h50, 32'h0, 1'b0, 1'b1, 32'h0, "rd word 0x50");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
